// File: rtl/dct_mem_pkg.sv
// rtl/dct_mem_pkg.sv - shared parameters and state type for the DCT result memory
package dct_mem_pkg;

  localparam int DATA_W    = 192;
  localparam int RA_W      = 10;
  localparam int CA_W      = 4;
  localparam int NUM_WORDS = 1 << (RA_W + CA_W);
  localparam int COEF_W    = 12;
  localparam int COEF_N    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/stream_fifo2.sv
// rtl/stream_fifo2.sv - two-entry FIFO whose head register drives the output stream directly
module stream_fifo2 #(
  parameter int W = 192
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         valid,
  output logic [1:0]   count
);

  logic [W-1:0] tail;
  logic         pop_ok;

  // A pop on an empty FIFO is meaningless; ignore it rather than underflow.
  assign pop_ok = pop && (count != 2'd0);
  assign valid  = (count != 2'd0);

  // Entries shift toward head on pop so head is always a plain register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               tail <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dct_result_streamer.sv
// rtl/dct_result_streamer.sv - sequential SRAM reader streaming DCT result words over valid/ready
module dct_result_streamer #(
  parameter int DATA_W    = dct_mem_pkg::DATA_W,
  parameter int RA_W      = dct_mem_pkg::RA_W,
  parameter int CA_W      = dct_mem_pkg::CA_W,
  parameter int NUM_WORDS = dct_mem_pkg::NUM_WORDS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [RA_W+CA_W-1:0] len_m1,
  output logic [RA_W-1:0]      RA,
  output logic [CA_W-1:0]      CA,
  output logic                 NCE,
  output logic                 NWRT,
  input  logic [DATA_W-1:0]    mem_q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  import dct_mem_pkg::*;

  localparam int AW = RA_W + CA_W;

  if ((NUM_WORDS != (1 << AW)) || (DATA_W != COEF_W * COEF_N)) begin : g_bad_geometry
    $error("dct_result_streamer: NUM_WORDS/DATA_W inconsistent with address and coefficient widths");
  end

  state_t        state;
  logic [AW-1:0] addr;
  logic [AW-1:0] len_q;
  logic [AW-1:0] out_index;
  logic          inflight;
  logic [1:0]    fifo_count;
  logic          pop;
  logic          issue;
  logic          last_issue;
  logic          final_hs;

  // Words already owed to the FIFO (stored + in flight) minus the one leaving now must stay below 2.
  assign pop        = out_valid & out_ready;
  assign issue      = (state == RUN) &&
                      (({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
  assign last_issue = issue && (addr == len_q);
  assign final_hs   = pop && out_last;

  assign RA       = addr[AW-1:CA_W];
  assign CA       = addr[CA_W-1:0];
  assign NCE      = ~issue;
  assign NWRT     = 1'b1;
  assign busy     = (state != IDLE);
  assign out_last = out_valid && (out_index == len_q);

  // Read data returns one cycle after issue and is pushed without condition.
  stream_fifo2 #(
    .W(DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight),
    .pop   (pop),
    .din   (mem_q),
    .head  (out_data),
    .valid (out_valid),
    .count (fifo_count)
  );

  // Sequencer: state, read address, latched length, output index and done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      len_q     <= '0;
      out_index <= '0;
      inflight  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      if (issue) addr <= addr + 1'b1;
      if (pop)   out_index <= out_index + 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            len_q     <= len_m1;
            addr      <= '0;
            out_index <= '0;
          end
        end
        RUN: begin
          if (last_issue) state <= DRAIN;
        end
        DRAIN: begin
          if (final_hs) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dct_result_streamer.sv
// tb/tb_dct_result_streamer.sv - directed self-checking bench for dct_result_streamer
module tb_dct_result_streamer;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [13:0]  len_m1;
  logic [9:0]   RA;
  logic [3:0]   CA;
  logic         NCE;
  logic         NWRT;
  logic [191:0] mem_q = '0;
  logic         out_valid;
  logic         out_ready;
  logic [191:0] out_data;
  logic         out_last;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int credit_viol = 0;
  int outstanding;

  int           iss_addr[$];
  int           iss_cyc[$];
  int           hs_cyc[$];
  logic [191:0] hs_data[$];
  bit           hs_last[$];

  always #5 clk = ~clk;

  dct_result_streamer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len_m1    (len_m1),
    .RA        (RA),
    .CA        (CA),
    .NCE       (NCE),
    .NWRT      (NWRT),
    .mem_q     (mem_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [191:0] sram_word(input int a);
    logic [31:0] x;
    x = (a * 32'h9E3779B1) ^ 32'h0000_5A5A;
    return {x, ~x, x ^ 32'hFFFF_0000, x + 32'd1, x - 32'd1, {x[15:0], x[31:16]}};
  endfunction

  // SRAM model: one-cycle read latency
  always @(posedge clk) begin
    if (!NCE) mem_q <= sram_word(int'({RA, CA}));
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Mid-cycle monitor: issues, handshakes and the outstanding-word credit bound
  always @(negedge clk) begin
    if (!reset) begin
      outstanding = iss_addr.size() - hs_cyc.size();
      if (outstanding > 2) credit_viol++;
      if (!NCE) begin
        if (outstanding - int'(out_valid && out_ready) >= 2) credit_viol++;
        iss_addr.push_back(int'({RA, CA}));
        iss_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        hs_cyc.push_back(cyc);
        hs_data.push_back(out_data);
        hs_last.push_back(out_last);
      end
    end
  end

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_queues();
    iss_addr.delete(); iss_cyc.delete();
    hs_cyc.delete(); hs_data.delete(); hs_last.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ctl"}, {RA, CA, NCE, NWRT, out_valid, out_last, busy, done},
          {10'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    check({tag, " data"}, out_data, 192'd0);
  endtask

  // Called right after a rising edge; start is high in the current cycle c
  task automatic run(input int len, input bit rnd, input int inject_at, input int abort_at,
                     output int c, output int done_cyc);
    clear_queues();
    len_m1   = 14'(len);
    start    = 1'b1;
    c        = cyc;
    done_cyc = -1;
    for (int k = 0; k < 4 * (len + 1) + 64; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (inject_at >= 0 && cyc == c + inject_at) begin
        start  = 1'b1;
        len_m1 = 14'd3;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (abort_at >= 0 && hs_cyc.size() >= abort_at) begin
        done_cyc = -2;
        return;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic verify(input string tag, input int len, input bit full_rate, input int c,
                        input int done_cyc);
    int n;
    int e;
    n = len + 1;
    check({tag, " done_seen"}, done_cyc >= 0, 1'b1);
    check({tag, " n_issue"}, iss_addr.size(), n);
    e = 0;
    foreach (iss_addr[i]) if (iss_addr[i] != i) e++;
    check({tag, " addr_seq"}, e, 0);
    check({tag, " n_hs"}, hs_data.size(), n);
    e = 0;
    foreach (hs_data[i]) if (hs_data[i] !== sram_word(i) || hs_last[i] != (i == len)) e++;
    check({tag, " data_last"}, e, 0);
    if (full_rate) begin
      check({tag, " first_issue"}, (iss_cyc.size() > 0) ? iss_cyc[0] : -1, c + 1);
      e = 0;
      foreach (iss_cyc[i]) if (iss_cyc[i] != c + 1 + i) e++;
      check({tag, " issue_gaps"}, e, 0);
      check({tag, " first_hs"}, (hs_cyc.size() > 0) ? hs_cyc[0] : -1, c + 3);
      e = 0;
      foreach (hs_cyc[i]) if (hs_cyc[i] != c + 3 + i) e++;
      check({tag, " hs_gaps"}, e, 0);
      check({tag, " done_cycle"}, done_cyc, c + 3 + n);
    end
    check({tag, " credit"}, credit_viol, 0);
  endtask

  initial begin
    int c;
    int d;
    int dn;
    reset     = 1'b1;
    start     = 1'b0;
    len_m1    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // 16 words at full rate
    run(15, 1'b0, -1, -1, c, d);
    verify("t1_len16", 15, 1'b1, c, d);
    check("t1 busy_in_done_cycle", busy, 1'b0);

    // Single word, started in the previous done cycle
    run(0, 1'b0, -1, -1, c, d);
    verify("t2_len1", 0, 1'b1, c, d);

    // 64 words with random back-pressure
    run(63, 1'b1, -1, -1, c, d);
    verify("t3_rand64", 63, 1'b0, c, d);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t3 done_width", done, 1'b0);

    // start with a different length while running is ignored
    run(15, 1'b0, 5, -1, c, d);
    verify("t4_start_in_run", 15, 1'b1, c, d);
    dn = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    check("t4 extra_done", dn, 0);
    check("t4 extra_issue", iss_addr.size(), 16);

    // reset after word 7 of 32 aborts without done
    run(31, 1'b0, -1, 7, c, d);
    check("t5 reached_abort", d, -2);
    reset = 1'b1;
    #1;
    check_reset_outputs("t5 abort");
    dn = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    check("t5 no_done", dn, 0);
    check_reset_outputs("t5 held");
    reset = 1'b0;
    clear_queues();
    @(posedge clk); #1;
    check("t5 idle_after_release", {busy, NCE}, 2'b01);
    run(3, 1'b0, -1, -1, c, d);
    verify("t5_len4", 3, 1'b1, c, d);

    // Full memory depth
    run(16383, 1'b0, -1, -1, c, d);
    verify("t6_full", 16383, 1'b1, c, d);
    check("t6 final_addr", (iss_addr.size() > 0) ? iss_addr[$] : -1, 16383);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
